// File: rtl/sdrahb_cmd_expander.sv
// Purpose : pops burst commands from the SDRAM-side CDC FIFO and expands each into per-beat address/control transfers.
// Latency : RD_EN is combinational in the pop cycle; the first beat is valid the next cycle; back-to-back bursts have no gap.
// Backpr. : OUT_ADDR/OUT_WRITE/OUT_LAST hold while OUT_READY=0; no pop until the last beat is accepted. Macro SDRAHB_CMD_WRAP_EN enables WRAP bursts.
module sdrahb_cmd_expander #(
    parameter int ADDR_WIDTH = 24,
    parameter int LEN_WIDTH  = 4,
    parameter int BEAT_BYTES = 4,
    parameter int DATA_WIDTH = ADDR_WIDTH + LEN_WIDTH + 2
) (
    input  logic                  CLK_WR,
    input  logic                  AW_RST_N,
    input  logic [DATA_WIDTH-1:0] FIFO_DATA,
    input  logic                  FIFO_EMPTY,
    output logic                  RD_EN,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [ADDR_WIDTH-1:0] OUT_ADDR,
    output logic                  OUT_WRITE,
    output logic                  OUT_LAST,
    output logic                  BUSY
);

    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;

    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  wr;
    logic                  last;
    logic [LEN_WIDTH-1:0]  beats_left;

    // Head-entry fields: {WRITE, WRAP, LEN, ADDR}
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  cmd_write;

    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] step_addr;

    assign cmd_addr  = FIFO_DATA[ADDR_WIDTH-1:0];
    assign cmd_len   = FIFO_DATA[ADDR_WIDTH +: LEN_WIDTH];
    assign cmd_write = FIFO_DATA[DATA_WIDTH-1];
    assign next_addr = cur_addr + ADDR_WIDTH'(BEAT_BYTES);

`ifdef SDRAHB_CMD_WRAP_EN
    logic                  cmd_wrap;
    logic                  wrap_ok;
    logic [ADDR_WIDTH-1:0] load_mask;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    assign cmd_wrap = FIFO_DATA[ADDR_WIDTH+LEN_WIDTH];

    // Wrap only for 2/4/8/16-beat bursts; the mask is all-ones for INCR so one update expression serves both
    always_comb begin
        wrap_ok   = cmd_wrap && (cmd_len != '0)
                    && ((cmd_len & (cmd_len + LEN_WIDTH'(1))) == '0)
                    && (32'(cmd_len) < 32'd16);
        load_mask = '1;
        if (wrap_ok) begin
            load_mask = ((ADDR_WIDTH'(cmd_len) + ADDR_WIDTH'(1)) << BEAT_SHIFT) - ADDR_WIDTH'(1);
        end
        step_addr = (cur_addr & ~wrap_mask) | (next_addr & wrap_mask);
    end
`else
    logic cmd_wrap_unused;

    assign cmd_wrap_unused = FIFO_DATA[ADDR_WIDTH+LEN_WIDTH];

    // Without wrap support every burst increments linearly, rolling over at the top of the address space
    always_comb begin
        step_addr = next_addr;
    end
`endif

    // State register
    always_ff @(posedge CLK_WR or negedge AW_RST_N) begin
        if (!AW_RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter BURST on a pop; leave only when the last beat is accepted with nothing to pop
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (RD_EN) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                if (OUT_READY && last) begin
                    state_d = RD_EN ? BURST : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: beat presentation from registers, pop when idle or on the last-beat handshake; pop suppressed in reset
    always_comb begin
        OUT_VALID = (state_q == BURST);
        BUSY      = (state_q == BURST);
        OUT_LAST  = (state_q == BURST) && last;
        OUT_ADDR  = cur_addr;
        OUT_WRITE = wr;
        RD_EN     = AW_RST_N && !FIFO_EMPTY
                    && ((state_q == IDLE) || ((state_q == BURST) && OUT_READY && last));
    end

    // Beat datapath: load on pop, advance address and beat count on each accepted non-last beat
    always_ff @(posedge CLK_WR or negedge AW_RST_N) begin
        if (!AW_RST_N) begin
            cur_addr   <= '0;
            wr         <= 1'b0;
            last       <= 1'b0;
            beats_left <= '0;
`ifdef SDRAHB_CMD_WRAP_EN
            wrap_mask  <= '1;
`endif
        end else if (RD_EN) begin
            cur_addr   <= cmd_addr;
            wr         <= cmd_write;
            last       <= (cmd_len == '0);
            beats_left <= cmd_len;
`ifdef SDRAHB_CMD_WRAP_EN
            wrap_mask  <= load_mask;
`endif
        end else if (OUT_VALID && OUT_READY && !last) begin
            cur_addr   <= step_addr;
            last       <= (beats_left == LEN_WIDTH'(1));
            beats_left <= beats_left - LEN_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_sdrahb_cmd_expander.sv
// Purpose : randomized and directed check of sdrahb_cmd_expander against a queue-based burst model.
// Latency : model expects pop in the FIFO-non-empty cycle and beats from the following cycle, gapless between bursts.
// Backpr. : OUT_READY is randomized; the expected head beat must be presented unchanged until accepted.
module tb_sdrahb_cmd_expander;

    typedef struct packed {
        logic [23:0] addr;
        logic        wr;
        logic        last;
    } beat_t;

    logic        CLK_WR;
    logic        AW_RST_N;
    logic [29:0] FIFO_DATA;
    logic        FIFO_EMPTY;
    logic        RD_EN;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [23:0] OUT_ADDR;
    logic        OUT_WRITE;
    logic        OUT_LAST;
    logic        BUSY;

    logic [29:0] fifo_q[$];
    beat_t       exp_q[$];
    beat_t       obs_q[$];
    int          n_vec;
    int          n_err;
    int          rd_cnt;
    int          vld_cnt;

    sdrahb_cmd_expander dut (
        .CLK_WR     (CLK_WR),
        .AW_RST_N   (AW_RST_N),
        .FIFO_DATA  (FIFO_DATA),
        .FIFO_EMPTY (FIFO_EMPTY),
        .RD_EN      (RD_EN),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .OUT_ADDR   (OUT_ADDR),
        .OUT_WRITE  (OUT_WRITE),
        .OUT_LAST   (OUT_LAST),
        .BUSY       (BUSY)
    );

    initial CLK_WR = 1'b0;
    always #5 CLK_WR = ~CLK_WR;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [29:0] mk_cmd(input logic wr, input logic wrap, input int len, input logic [23:0] addr);
        logic [3:0] l;
        l = len[3:0];
        return {wr, wrap, l, addr};
    endfunction

    // Reference expansion of one command into its beat sequence
    function automatic void expand(input logic [29:0] e);
        logic [31:0] addr;
        logic [31:0] a;
        int          len;
        int          total;
        logic        wr;
        logic        wrap_on;
        addr    = {8'h00, e[23:0]};
        len     = int'(e[27:24]);
        wr      = e[29];
        wrap_on = 1'b0;
`ifdef SDRAHB_CMD_WRAP_EN
        wrap_on = e[28] && (len == 1 || len == 3 || len == 7 || len == 15);
`endif
        total = (len + 1) * 4;
        for (int i = 0; i <= len; i++) begin
            if (wrap_on) a = (addr - addr % total) + ((addr % total + i * 4) % total);
            else         a = (addr + i * 4) & 32'h00FF_FFFF;
            exp_q.push_back('{addr: a[23:0], wr: wr, last: (i == len)});
        end
    endfunction

    function automatic logic [29:0] rand_cmd();
        logic [31:0] r;
        logic [23:0] a;
        r = $urandom;
        if ($urandom_range(0, 3) == 0) a = 24'hFFFFC0 + 24'($urandom_range(0, 15) * 4);
        else                           a = r[23:0] & 24'hFFFFFC;
        return mk_cmd(r[31], r[30], int'(r[29:26]), a);
    endfunction

    // One clock cycle: drive inputs, compare at the falling edge, advance the model
    task automatic step(input int rdy_pct);
        logic  exp_vld;
        logic  exp_rd;
        logic [31:0] junk;
        beat_t hd;
        OUT_READY  = ($urandom_range(0, 99) < rdy_pct);
        FIFO_EMPTY = (fifo_q.size() == 0);
        junk       = $urandom;
        FIFO_DATA  = (fifo_q.size() == 0) ? junk[29:0] : fifo_q[0];
        @(negedge CLK_WR);
        exp_vld = (exp_q.size() != 0);
        exp_rd  = (fifo_q.size() != 0) && (!exp_vld || (OUT_READY && exp_q.size() == 1));
        check_eq("rd_en", 32'(RD_EN), 32'(exp_rd));
        check_eq("out_valid", 32'(OUT_VALID), 32'(exp_vld));
        check_eq("busy", 32'(BUSY), 32'(exp_vld));
        if (exp_vld) begin
            hd = exp_q[0];
            check_eq("out_addr", 32'(OUT_ADDR), 32'(hd.addr));
            check_eq("out_write", 32'(OUT_WRITE), 32'(hd.wr));
            check_eq("out_last", 32'(OUT_LAST), 32'(hd.last));
        end else begin
            check_eq("out_last_idle", 32'(OUT_LAST), 32'd0);
        end
        if (RD_EN) rd_cnt++;
        if (OUT_VALID) vld_cnt++;
        if (OUT_VALID && OUT_READY) obs_q.push_back('{addr: OUT_ADDR, wr: OUT_WRITE, last: OUT_LAST});
        if (exp_vld && OUT_READY) void'(exp_q.pop_front());
        if (exp_rd) expand(fifo_q.pop_front());
        @(posedge CLK_WR);
        #1;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        rd_cnt  = 0;
        vld_cnt = 0;
    endtask

    task automatic check_obs(input string tag, input int idx, input logic [23:0] a, input logic l);
        if (idx < obs_q.size()) begin
            check_eq({tag, "_addr"}, 32'(obs_q[idx].addr), 32'(a));
            check_eq({tag, "_last"}, 32'(obs_q[idx].last), 32'(l));
        end
    endtask

    initial begin
        int pct;
        n_vec = 0;
        n_err = 0;
        clear_obs();
        AW_RST_N   = 1'b0;
        OUT_READY  = 1'b0;
        FIFO_EMPTY = 1'b1;
        FIFO_DATA  = '0;
        #2;
        check_eq("rst_valid", 32'(OUT_VALID), 32'd0);
        check_eq("rst_busy", 32'(BUSY), 32'd0);
        check_eq("rst_last", 32'(OUT_LAST), 32'd0);
        check_eq("rst_write", 32'(OUT_WRITE), 32'd0);
        check_eq("rst_addr", 32'(OUT_ADDR), 32'd0);
        FIFO_EMPTY = 1'b0;
        FIFO_DATA  = mk_cmd(1'b1, 1'b0, 3, 24'h000100);
        #1;
        check_eq("rst_rd_en", 32'(RD_EN), 32'd0);
        FIFO_EMPTY = 1'b1;
        @(posedge CLK_WR);
        @(posedge CLK_WR);
        #1;
        AW_RST_N = 1'b1;

        // Single INCR write burst
        clear_obs();
        fifo_q.push_back(mk_cmd(1'b1, 1'b0, 3, 24'h000100));
        repeat (6) step(100);
        check_eq("incr_n", 32'(obs_q.size()), 32'd4);
        check_obs("incr0", 0, 24'h000100, 1'b0);
        check_obs("incr1", 1, 24'h000104, 1'b0);
        check_obs("incr2", 2, 24'h000108, 1'b0);
        check_obs("incr3", 3, 24'h00010C, 1'b1);
        if (obs_q.size() > 0) check_eq("incr_write", 32'(obs_q[0].wr), 32'd1);
        check_eq("incr_pops", 32'(rd_cnt), 32'd1);

        // WRAP request, 4 beats starting mid-block
        clear_obs();
        fifo_q.push_back(mk_cmd(1'b0, 1'b1, 3, 24'h000018));
        repeat (6) step(100);
        check_eq("wrap_n", 32'(obs_q.size()), 32'd4);
        check_obs("wrap0", 0, 24'h000018, 1'b0);
        check_obs("wrap1", 1, 24'h00001C, 1'b0);
`ifdef SDRAHB_CMD_WRAP_EN
        check_obs("wrap2", 2, 24'h000010, 1'b0);
        check_obs("wrap3", 3, 24'h000014, 1'b1);
`else
        check_obs("wrap2", 2, 24'h000020, 1'b0);
        check_obs("wrap3", 3, 24'h000024, 1'b1);
`endif

        // Backpressure on beat 0 for 3 cycles
        clear_obs();
        fifo_q.push_back(mk_cmd(1'b1, 1'b0, 1, 24'h000040));
        step(100);
        repeat (3) step(0);
        repeat (3) step(100);
        check_eq("bp_n", 32'(obs_q.size()), 32'd2);
        check_obs("bp0", 0, 24'h000040, 1'b0);
        check_obs("bp1", 1, 24'h000044, 1'b1);
        check_eq("bp_vld_cycles", 32'(vld_cnt), 32'd5);

        // Back-to-back bursts with no idle cycle
        clear_obs();
        fifo_q.push_back(mk_cmd(1'b0, 1'b0, 0, 24'h000200));
        fifo_q.push_back(mk_cmd(1'b1, 1'b0, 1, 24'h000300));
        repeat (5) step(100);
        check_eq("b2b_n", 32'(obs_q.size()), 32'd3);
        check_obs("b2b0", 0, 24'h000200, 1'b1);
        check_obs("b2b1", 1, 24'h000300, 1'b0);
        check_obs("b2b2", 2, 24'h000304, 1'b1);
        check_eq("b2b_vld_cycles", 32'(vld_cnt), 32'd3);
        check_eq("b2b_pops", 32'(rd_cnt), 32'd2);

        // Address roll-over at the top of the space
        clear_obs();
        fifo_q.push_back(mk_cmd(1'b0, 1'b0, 1, 24'hFFFFFC));
        repeat (4) step(100);
        check_obs("roll0", 0, 24'hFFFFFC, 1'b0);
        check_obs("roll1", 1, 24'h000000, 1'b1);

        // Reset in the middle of an 8-beat burst
        clear_obs();
        fifo_q.push_back(mk_cmd(1'b1, 1'b0, 7, 24'h000400));
        repeat (4) step(100);
        check_eq("pre_rst_beats", 32'(obs_q.size()), 32'd3);
        AW_RST_N = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        #1;
        check_eq("midrst_valid", 32'(OUT_VALID), 32'd0);
        check_eq("midrst_busy", 32'(BUSY), 32'd0);
        check_eq("midrst_addr", 32'(OUT_ADDR), 32'd0);
        @(posedge CLK_WR);
        @(posedge CLK_WR);
        #1;
        AW_RST_N = 1'b1;
        repeat (5) step(100);

        // Randomized traffic at several backpressure levels
        for (int ph = 0; ph < 3; ph++) begin
            case (ph)
                0:       pct = 100;
                1:       pct = 70;
                default: pct = 30;
            endcase
            for (int c = 0; c < 600; c++) begin
                if (fifo_q.size() < 3 && $urandom_range(0, 2) == 0) fifo_q.push_back(rand_cmd());
                step(pct);
            end
        end
        for (int c = 0; c < 300 && (fifo_q.size() != 0 || exp_q.size() != 0); c++) step(100);
        check_eq("drain_left", 32'(fifo_q.size() + exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
